// File: rtl/mem_stage.sv
// rv32i memory-access stage: EX/MEM register, data-memory port drive, wait-state
// stall with timeout, and sticky trapping of misaligned / timed-out accesses.
module mem_stage #(
   parameter int         WAIT_MAX = 15,
   parameter logic [5:0] MN_NOP   = 6'd0,
   parameter logic [5:0] MN_LB    = 6'd11,
   parameter logic [5:0] MN_LH    = 6'd12,
   parameter logic [5:0] MN_LW    = 6'd13,
   parameter logic [5:0] MN_LBU   = 6'd14,
   parameter logic [5:0] MN_LHU   = 6'd15,
   parameter logic [5:0] MN_SB    = 6'd16,
   parameter logic [5:0] MN_SH    = 6'd17,
   parameter logic [5:0] MN_SW    = 6'd18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  i_mnemonic,
   input  logic [4:0]  i_rd_addr,
   input  logic [31:0] i_ALUout,
   input  logic [31:0] i_rs2_data,
   input  logic        i_rd_wr,
   input  logic        i_DM_READY,
   output logic        o_DM_CS,
   output logic [3:0]  o_DM_WEB,
   output logic [29:0] o_DM_A,
   output logic [31:0] o_DM_DO,
   output logic [5:0]  o_mnemonic,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_ALUout,
   output logic        o_rd_wr,
   output logic        o_stall,
   output logic        o_misalign,
   output logic        o_bus_err,
   output logic [31:0] o_err_addr
);

   localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

   typedef enum logic {S_RUN, S_WAIT} state_t;

   state_t           r_state, w_state_nxt;
   logic [WCW-1:0]   r_wcnt, w_wcnt_nxt;
   logic [5:0]       r_mn;
   logic [4:0]       r_rd;
   logic [31:0]      r_alu, r_st, r_err_addr;
   logic             r_wr, r_misalign, r_bus_err;

   logic             w_is_mem, w_is_st, w_half, w_word, w_mis, w_access;
   logic             w_abort, w_stall, w_complete, w_trap, w_cs;
   logic [3:0]       w_web_st;
   logic [31:0]      w_do;

   // Access classification of the instruction held in the stage
   always_comb begin
      w_is_mem = 1'b0;
      w_is_st  = 1'b0;
      w_half   = 1'b0;
      w_word   = 1'b0;
      w_web_st = 4'hF;
      w_do     = 32'h0;
      case (r_mn)
         MN_LB, MN_LBU: w_is_mem = 1'b1;
         MN_LH, MN_LHU: begin w_is_mem = 1'b1; w_half = 1'b1; end
         MN_LW:         begin w_is_mem = 1'b1; w_word = 1'b1; end
         MN_SB: begin
            w_is_mem = 1'b1; w_is_st = 1'b1;
            w_web_st = ~(4'b0001 << r_alu[1:0]);
            w_do     = {4{r_st[7:0]}};
         end
         MN_SH: begin
            w_is_mem = 1'b1; w_is_st = 1'b1; w_half = 1'b1;
            w_web_st = r_alu[1] ? 4'b0011 : 4'b1100;
            w_do     = {2{r_st[15:0]}};
         end
         MN_SW: begin
            w_is_mem = 1'b1; w_is_st = 1'b1; w_word = 1'b1;
            w_web_st = 4'b0000;
            w_do     = r_st;
         end
         default: ;
      endcase
   end

   assign w_mis    = (w_half && r_alu[0]) || (w_word && (r_alu[1:0] != 2'b00));
   assign w_access = w_is_mem && !w_mis;

   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_abort     = 1'b0;
      case (r_state)
         S_RUN: begin
            if (w_access && !i_DM_READY) begin
               w_state_nxt = S_WAIT;
               w_wcnt_nxt  = '0;
            end
         end
         S_WAIT: begin
            // READY arriving on the timeout cycle completes the access instead
            if (i_DM_READY) begin
               w_state_nxt = S_RUN;
            end else if (r_wcnt == WCW'(WAIT_MAX - 1)) begin
               w_abort     = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_wcnt_nxt  = r_wcnt + 1'b1;
            end
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   assign w_stall    = w_access && !i_DM_READY && !w_abort;
   assign w_trap     = w_mis || w_abort;
   assign w_complete = !w_access || i_DM_READY || w_abort;
   assign w_cs       = w_access && !w_abort;

   assign o_DM_CS    = w_cs;
   assign o_DM_WEB   = (w_cs && w_is_st) ? w_web_st : 4'hF;
   assign o_DM_A     = r_alu[31:2];
   assign o_DM_DO    = w_do;
   assign o_mnemonic = (w_complete && !w_trap) ? r_mn : MN_NOP;
   assign o_rd_wr    = w_complete && !w_trap && r_wr;
   assign o_rd_addr  = r_rd;
   assign o_ALUout   = r_alu;
   assign o_stall    = w_stall;
   assign o_misalign = r_misalign;
   assign o_bus_err  = r_bus_err;
   assign o_err_addr = r_err_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_RUN;
         r_wcnt     <= '0;
         r_mn       <= MN_NOP;
         r_rd       <= 5'd0;
         r_alu      <= 32'h0;
         r_st       <= 32'h0;
         r_wr       <= 1'b0;
         r_misalign <= 1'b0;
         r_bus_err  <= 1'b0;
         r_err_addr <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
         if (!w_stall) begin
            r_mn  <= i_mnemonic;
            r_rd  <= i_rd_addr;
            r_alu <= i_ALUout;
            r_st  <= i_rs2_data;
            r_wr  <= i_rd_wr;
         end
         // Only the first trap after reset records its address
         if (w_trap && !r_misalign && !r_bus_err) r_err_addr <= r_alu;
         if (w_mis)   r_misalign <= 1'b1;
         if (w_abort) r_bus_err  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed + randomized bench for mem_stage against a per-cycle behavioural model
// that tracks the held instruction and how many cycles it has stalled.
module tb_mem_stage;

   localparam int WAIT_MAX = 15;
   localparam logic [5:0] NOP = 6'd0, ADD = 6'd1, LH = 6'd12, LW = 6'd13;
   localparam logic [5:0] SB = 6'd16, SH = 6'd17, SW = 6'd18;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  i_mnemonic = 6'd0;
   logic [4:0]  i_rd_addr = 5'd0;
   logic [31:0] i_ALUout = 32'h0, i_rs2_data = 32'h0;
   logic        i_rd_wr = 1'b0, i_DM_READY = 1'b1;
   logic        o_DM_CS, o_rd_wr, o_stall, o_misalign, o_bus_err;
   logic [3:0]  o_DM_WEB;
   logic [29:0] o_DM_A;
   logic [31:0] o_DM_DO, o_ALUout, o_err_addr;
   logic [5:0]  o_mnemonic;
   logic [4:0]  o_rd_addr;

   int checks = 0, failures = 0;

   // model state: instruction in the stage, stall cycles spent on it, sticky flags
   logic [5:0]  m_mn;
   logic [4:0]  m_rd;
   logic [31:0] m_alu, m_st, m_ea;
   logic        m_wr, m_mis, m_berr;
   int          m_n;

   mem_stage dut (
      .clk(clk), .rst(rst),
      .i_mnemonic(i_mnemonic), .i_rd_addr(i_rd_addr), .i_ALUout(i_ALUout),
      .i_rs2_data(i_rs2_data), .i_rd_wr(i_rd_wr), .i_DM_READY(i_DM_READY),
      .o_DM_CS(o_DM_CS), .o_DM_WEB(o_DM_WEB), .o_DM_A(o_DM_A), .o_DM_DO(o_DM_DO),
      .o_mnemonic(o_mnemonic), .o_rd_addr(o_rd_addr), .o_ALUout(o_ALUout),
      .o_rd_wr(o_rd_wr), .o_stall(o_stall), .o_misalign(o_misalign),
      .o_bus_err(o_bus_err), .o_err_addr(o_err_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int acc_size(input logic [5:0] mn);
      case (mn)
         6'd11, 6'd14, 6'd16: return 1;
         6'd12, 6'd15, 6'd17: return 2;
         6'd13, 6'd18:        return 4;
         default:             return 0;
      endcase
   endfunction

   task automatic model_check(input logic rdy);
      int s, off;
      logic mem, st, mis, acc, abrt, cs, stall, done, trap;
      logic [3:0]  web;
      logic [31:0] dout;
      s     = acc_size(m_mn);
      off   = int'(m_alu[1:0]);
      mem   = (s != 0);
      st    = (m_mn >= 6'd16) && (m_mn <= 6'd18);
      mis   = mem && ((off % (mem ? s : 1)) != 0);
      acc   = mem && !mis;
      abrt  = acc && !rdy && (m_n == WAIT_MAX);
      cs    = acc && !abrt;
      stall = acc && !rdy && !abrt;
      done  = !acc || rdy || abrt;
      trap  = mis || abrt;
      web   = 4'hF;
      for (int l = 0; l < 4; l++)
         if (cs && st && l >= off && l < off + s) web[l] = 1'b0;
      if (!st)         dout = 32'h0;
      else if (s == 1) dout = {24'h0, m_st[7:0]} * 32'h01010101;
      else if (s == 2) dout = {16'h0, m_st[15:0]} * 32'h00010001;
      else             dout = m_st;
      chk("cs",     {31'h0, o_DM_CS},    {31'h0, cs});
      chk("web",    {28'h0, o_DM_WEB},   {28'h0, web});
      chk("addr",   {2'b0, o_DM_A},      {2'b0, m_alu[31:2]});
      chk("dout",   o_DM_DO,             dout);
      chk("mn",     {26'h0, o_mnemonic}, (done && !trap) ? {26'h0, m_mn} : 32'h0);
      chk("rd",     {27'h0, o_rd_addr},  {27'h0, m_rd});
      chk("alu",    o_ALUout,            m_alu);
      chk("rd_wr",  {31'h0, o_rd_wr},    {31'h0, done && !trap && m_wr});
      chk("stall",  {31'h0, o_stall},    {31'h0, stall});
      chk("mis",    {31'h0, o_misalign}, {31'h0, m_mis});
      chk("berr",   {31'h0, o_bus_err},  {31'h0, m_berr});
      chk("eaddr",  o_err_addr,          m_ea);
      if (trap && !m_mis && !m_berr) m_ea = m_alu;
      if (mis)  m_mis  = 1'b1;
      if (abrt) m_berr = 1'b1;
      if (stall) m_n++;
      else begin
         m_mn = i_mnemonic; m_rd = i_rd_addr; m_alu = i_ALUout;
         m_st = i_rs2_data; m_wr = i_rd_wr; m_n = 0;
      end
   endtask

   // drive the next EX instruction plus READY for the stage's current access
   task automatic step(input logic [5:0] mn, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] st, input logic wr, input logic rdy);
      @(negedge clk);
      i_mnemonic = mn; i_rd_addr = rd; i_ALUout = alu; i_rs2_data = st;
      i_rd_wr = wr; i_DM_READY = rdy;
      #1 model_check(rdy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      i_mnemonic = NOP; i_rd_addr = 5'd0; i_ALUout = 32'h0; i_rs2_data = 32'h0;
      i_rd_wr = 1'b0; i_DM_READY = 1'b1;
      #1;
      chk("rst_cs",   {31'h0, o_DM_CS},    32'h0);
      chk("rst_web",  {28'h0, o_DM_WEB},   32'hF);
      chk("rst_addr", {2'b0, o_DM_A},      32'h0);
      chk("rst_do",   o_DM_DO,             32'h0);
      chk("rst_mn",   {26'h0, o_mnemonic}, 32'h0);
      chk("rst_rd",   {27'h0, o_rd_addr},  32'h0);
      chk("rst_alu",  o_ALUout,            32'h0);
      chk("rst_wr",   {31'h0, o_rd_wr},    32'h0);
      chk("rst_stall",{31'h0, o_stall},    32'h0);
      chk("rst_mis",  {31'h0, o_misalign}, 32'h0);
      chk("rst_berr", {31'h0, o_bus_err},  32'h0);
      chk("rst_ea",   o_err_addr,          32'h0);
      m_mn = NOP; m_rd = 5'd0; m_alu = 32'h0; m_st = 32'h0; m_wr = 1'b0;
      m_n = 0; m_mis = 1'b0; m_berr = 1'b0; m_ea = 32'h0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [5:0] pool [12] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
                             6'd16, 6'd17, 6'd18};

   initial begin
      do_reset();

      // stores: lane alignment and strobes
      step(SW, 5'd0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1);
      step(SB, 5'd0, 32'h103, 32'h000000A5, 1'b0, 1'b1);
      chk("sw_a",   {2'b0, o_DM_A},    32'h40);
      chk("sw_web", {28'h0, o_DM_WEB}, 32'h0);
      chk("sw_do",  o_DM_DO,           32'hDEADBEEF);
      step(SH, 5'd0, 32'h102, 32'h00001234, 1'b0, 1'b1);
      chk("sb_web", {28'h0, o_DM_WEB}, 32'h7);
      chk("sb_do",  o_DM_DO,           32'hA5A5A5A5);
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("sh_web", {28'h0, o_DM_WEB}, 32'h3);
      chk("sh_do",  o_DM_DO,           32'h12341234);

      // LW with three wait states
      step(LW, 5'd3, 32'h200, 32'h0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
         chk("lw_stall", {31'h0, o_stall},    32'h1);
         chk("lw_bub",   {26'h0, o_mnemonic}, 32'h0);
      end
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("lw_mn", {26'h0, o_mnemonic}, {26'h0, LW});
      chk("lw_wr", {31'h0, o_rd_wr},    32'h1);

      // misaligned accesses; only the first address is kept
      step(LH, 5'd4, 32'h201, 32'h0, 1'b1, 1'b1);
      step(LW, 5'd6, 32'h305, 32'h0, 1'b1, 1'b1);
      chk("lh_cs", {31'h0, o_DM_CS}, 32'h0);
      chk("lh_wr", {31'h0, o_rd_wr}, 32'h0);
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("mis_flag", {31'h0, o_misalign}, 32'h1);
      chk("mis_ea1",  o_err_addr,          32'h201);
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("mis_ea2",  o_err_addr,          32'h201);

      // READY arriving on the would-be timeout cycle: completion, no error
      step(LW, 5'd7, 32'h400, 32'h0, 1'b1, 1'b1);
      for (int k = 0; k < WAIT_MAX; k++) begin
         step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
         chk("late_stall", {31'h0, o_stall}, 32'h1);
      end
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("late_stall0", {31'h0, o_stall},    32'h0);
      chk("late_mn",     {26'h0, o_mnemonic}, {26'h0, LW});
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("late_berr",   {31'h0, o_bus_err},  32'h0);

      // timeout: exactly WAIT_MAX stall cycles, then abort
      step(LW, 5'd8, 32'h500, 32'h0, 1'b1, 1'b1);
      for (int k = 0; k < WAIT_MAX; k++) begin
         step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
         chk("to_stall", {31'h0, o_stall}, 32'h1);
      end
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("to_stall0", {31'h0, o_stall},    32'h0);
      chk("to_bub",    {26'h0, o_mnemonic}, 32'h0);
      chk("to_cs",     {31'h0, o_DM_CS},    32'h0);
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("to_berr",   {31'h0, o_bus_err},  32'h1);
      chk("to_ea",     o_err_addr,          32'h201);

      // reset in the middle of a wait, then a plain ALU op
      step(LW, 5'd9, 32'h600, 32'h0, 1'b1, 1'b1);
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      do_reset();
      step(ADD, 5'd5, 32'h7, 32'h0, 1'b1, 1'b1);
      step(NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("add_mn",  {26'h0, o_mnemonic}, {26'h0, ADD});
      chk("add_rd",  {27'h0, o_rd_addr},  32'h5);
      chk("add_alu", o_ALUout,            32'h7);
      chk("add_wr",  {31'h0, o_rd_wr},    32'h1);

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 400; k++) begin
         step(pool[$urandom_range(0, 11)], 5'($urandom), $urandom, $urandom,
              1'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
